generic_rr_onehot_arbiter: RTL and testbench

GENERIC_RR_ONEHOT_ARBITER -- requirements
Module: generic_rr_onehot_arbiter

---
 rtl/generic_rr_onehot_arbiter.sv | 115 +++++++++++
 tb/tb_generic_rr_onehot_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/generic_rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a ready/valid handshake.
// The priority pointer advances past each accepted grant so every requester is served in turn.
module generic_rr_onehot_arbiter #(
  parameter int WIDTH = 8,
  parameter int IDXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [WIDTH-1:0] gnt,
  output logic [IDXW-1:0]  gnt_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_r;
  logic [IDXW-1:0]  ptr_r;
  logic [IDXW-1:0]  next_ptr_s;
  logic [IDXW-1:0]  base_s;
  logic [IDXW-1:0]  win_idx_s;
  logic             win_found_s;
  logic [WIDTH-1:0] win_onehot_s;

  // Scan downward so the lowest offset from base is the last one to claim pick.
  function automatic logic [IDXW:0] rr_pick(input logic [WIDTH-1:0] r,
                                            input logic [IDXW-1:0]  base);
    logic            found;
    logic [IDXW-1:0] pick;
    int              pos;
    found = 1'b0;
    pick  = {IDXW{1'b0}};
    for (int k = WIDTH - 1; k >= 0; k--) begin
      pos   = int'(base) + k;
      pos   = (pos >= WIDTH) ? (pos - WIDTH) : pos;
      found = found | r[pos];
      pick  = r[pos] ? IDXW'(pos) : pick;
    end
    return {found, pick};
  endfunction

  // Select the scan origin (updated pointer on acceptance) and find the winner.
  always_comb begin
    next_ptr_s   = (gnt_idx == IDXW'(WIDTH - 1)) ? {IDXW{1'b0}} : (gnt_idx + IDXW'(1));
    base_s       = ptr_r;
    win_onehot_s = {WIDTH{1'b0}};
    if ((state_r == GRANT) && gnt_ready) begin
      base_s = next_ptr_s;
    end else begin
      base_s = ptr_r;
    end
    {win_found_s, win_idx_s}  = rr_pick(req, base_s);
    win_onehot_s[win_idx_s]   = 1'b1;
  end

  // Handshake FSM; the grant is committed until accepted, whatever req does meanwhile.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= {IDXW{1'b0}};
      gnt_valid <= 1'b0;
      gnt       <= {WIDTH{1'b0}};
      gnt_idx   <= {IDXW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            state_r   <= GRANT;
            gnt_valid <= 1'b1;
            gnt       <= win_onehot_s;
            gnt_idx   <= win_idx_s;
          end else begin
            state_r   <= IDLE;
            gnt_valid <= 1'b0;
            gnt       <= {WIDTH{1'b0}};
            gnt_idx   <= {IDXW{1'b0}};
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            ptr_r <= next_ptr_s;
            if (win_found_s) begin
              state_r   <= GRANT;
              gnt_valid <= 1'b1;
              gnt       <= win_onehot_s;
              gnt_idx   <= win_idx_s;
            end else begin
              state_r   <= IDLE;
              gnt_valid <= 1'b0;
              gnt       <= {WIDTH{1'b0}};
              gnt_idx   <= {IDXW{1'b0}};
            end
          end else begin
            state_r   <= GRANT;
            gnt_valid <= 1'b1;
            gnt       <= gnt;
            gnt_idx   <= gnt_idx;
          end
        end
        default: begin
          state_r   <= IDLE;
          ptr_r     <= {IDXW{1'b0}};
          gnt_valid <= 1'b0;
          gnt       <= {WIDTH{1'b0}};
          gnt_idx   <= {IDXW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generic_rr_onehot_arbiter.sv
// Directed + random bench for generic_rr_onehot_arbiter (WIDTH=8) with a queue scoreboard
// fed by an independent behavioural model and a per-cycle one-hot checker.
module tb_generic_rr_onehot_arbiter;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  req;
  logic          gnt_ready;
  logic          gnt_valid;
  logic [W-1:0]  gnt;
  logic [IW-1:0] gnt_idx;

  typedef struct packed {
    logic          v;
    logic [W-1:0]  g;
    logic [IW-1:0] i;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  int   m_valid = 0;
  int   m_idx   = 0;
  int   m_ptr   = 0;

  generic_rr_onehot_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt_ready (gnt_ready),
    .gnt_valid (gnt_valid),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx)
  );

  always #5 clk = ~clk;

  // Independent one-hot / index consistency checker, every cycle once reset has settled.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (gnt_valid === 1'b1) begin
        assert ((gnt != 8'h00) && ((gnt & (gnt - 8'h01)) == 8'h00) && (gnt[gnt_idx] === 1'b1))
        else begin
          failures++;
          $error("FAIL onehot gnt=%h idx=%0d required one-hot with gnt[idx]=1", gnt, gnt_idx);
        end
      end else begin
        assert ((gnt === 8'h00) && (gnt_idx === 3'd0))
        else begin
          failures++;
          $error("FAIL idle_zero gnt=%h idx=%0d required gnt=00 idx=0", gnt, gnt_idx);
        end
      end
    end
  end

  function automatic int scan(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      if (r[(p + k) % W]) return (p + k) % W;
    end
    return -1;
  endfunction

  // Drive one cycle at the negedge, predict with the model, then compare after the edge.
  task automatic step(input logic [W-1:0] r, input logic rdy, input logic rst);
    int   w;
    exp_t e;
    exp_t o;
    req       = r;
    gnt_ready = rdy;
    reset     = rst;
    if (rst) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (m_valid == 0) begin
      w = scan(r, m_ptr);
      if (w >= 0) begin m_valid = 1; m_idx = w; end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % W;
      w = scan(r, m_ptr);
      if (w >= 0) m_idx = w;
      else begin m_valid = 0; m_idx = 0; end
    end
    e.v = (m_valid != 0);
    e.g = (m_valid != 0) ? 8'(1 << m_idx) : 8'h00;
    e.i = 3'(m_idx);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = sb.pop_front();
    checks++;
    assert ({gnt_valid, gnt, gnt_idx} === {o.v, o.g, o.i})
    else begin
      failures++;
      $error("FAIL model got v=%b gnt=%h idx=%0d required v=%b gnt=%h idx=%0d",
             gnt_valid, gnt, gnt_idx, o.v, o.g, o.i);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [W-1:0] g,
                            input logic [IW-1:0] i);
    checks++;
    assert ({gnt_valid, gnt, gnt_idx} === {v, g, i})
    else begin
      failures++;
      $error("FAIL %s got v=%b gnt=%h idx=%0d required v=%b gnt=%h idx=%0d",
             tag, gnt_valid, gnt, gnt_idx, v, g, i);
    end
  endtask

  initial begin
    reset = 1'b1; req = 8'h00; gnt_ready = 1'b0;
    @(negedge clk);
    step(8'h00, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    chk_en = 1'b1;
    expect_out("reset", 1'b0, 8'h00, 3'd0);

    // S1: idle with no requests
    for (int c = 0; c < 10; c++) begin
      step(8'h00, 1'b0, 1'b0);
      expect_out("s1_idle", 1'b0, 8'h00, 3'd0);
    end

    // S2: two requesters alternate back to back
    step(8'h24, 1'b1, 1'b0); expect_out("s2_g0", 1'b1, 8'h04, 3'd2);
    step(8'h24, 1'b1, 1'b0); expect_out("s2_g1", 1'b1, 8'h20, 3'd5);
    step(8'h24, 1'b1, 1'b0); expect_out("s2_g2", 1'b1, 8'h04, 3'd2);
    step(8'h24, 1'b1, 1'b0); expect_out("s2_g3", 1'b1, 8'h20, 3'd5);
    step(8'h00, 1'b1, 1'b0); expect_out("s2_idle", 1'b0, 8'h00, 3'd0);

    // S3: committed grant held while not ready, even after req drops
    step(8'h01, 1'b0, 1'b0); expect_out("s3_grant", 1'b1, 8'h01, 3'd0);
    step(8'h01, 1'b0, 1'b0); expect_out("s3_hold0", 1'b1, 8'h01, 3'd0);
    for (int c = 1; c < 4; c++) begin
      step(8'h00, 1'b0, 1'b0); expect_out("s3_hold", 1'b1, 8'h01, 3'd0);
    end
    step(8'h00, 1'b1, 1'b0); expect_out("s3_idle", 1'b0, 8'h00, 3'd0);

    // S4: all requesting, pointer starts from 0 after reset
    step(8'h00, 1'b0, 1'b1); expect_out("s4_rst", 1'b0, 8'h00, 3'd0);
    for (int c = 0; c < 9; c++) begin
      step(8'hFF, 1'b1, 1'b0);
      expect_out("s4_walk", 1'b1, 8'(1 << (c % 8)), 3'(c % 8));
    end
    step(8'h00, 1'b1, 1'b0); expect_out("s4_idle", 1'b0, 8'h00, 3'd0);

    // S5: wrap from index 7 to 0
    step(8'h80, 1'b1, 1'b0); expect_out("s5_g7", 1'b1, 8'h80, 3'd7);
    step(8'h81, 1'b1, 1'b0); expect_out("s5_g0", 1'b1, 8'h01, 3'd0);
    step(8'h81, 1'b1, 1'b0); expect_out("s5_g7b", 1'b1, 8'h80, 3'd7);
    step(8'h00, 1'b1, 1'b0); expect_out("s5_idle", 1'b0, 8'h00, 3'd0);

    // S6: reset drops an outstanding grant and restores ptr=0
    step(8'h10, 1'b0, 1'b0); expect_out("s6_g4", 1'b1, 8'h10, 3'd4);
    step(8'h10, 1'b0, 1'b0); expect_out("s6_hold", 1'b1, 8'h10, 3'd4);
    step(8'h10, 1'b1, 1'b1); expect_out("s6_rst", 1'b0, 8'h00, 3'd0);
    step(8'h11, 1'b0, 1'b0); expect_out("s6_g0", 1'b1, 8'h01, 3'd0);
    step(8'h11, 1'b1, 1'b0); expect_out("s6_g4b", 1'b1, 8'h10, 3'd4);
    step(8'h00, 1'b1, 1'b0); expect_out("s6_idle", 1'b0, 8'h00, 3'd0);

    // Random traffic checked against the model
    for (int c = 0; c < 60; c++) begin
      step(8'($urandom), 1'($urandom_range(1, 0)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
